line_receiver: RTL and testbench
================================

// Module: line_receiver
// PURPOSE
//  Receive end of the line-transfer link: captures one line of COL 16-bit pixels
//  streamed by the sender while iomDmar is held low, into a ping-pong line buffer.
//  Completed lines are presented to downstream logic (VGA/processing) via a
//  random-access read port with an explicit release handshake.
//  Tracks line number within a frame of ROW lines.
// PARAMETERS
//  COL    800  pixels (16-bit words) per line
//  ROW    600  lines per frame
//  ADDR_W 10   read/write address width, >= clog2(COL)
//  ROW_W  10   line counter width, >= clog2(ROW)
// PORTS
//  imCLOCK      in   1       sole clock; all logic on rising edge
//  imRESET_N    in   1       asynchronous active-low reset
//  imDmar       in   1       transfer window, active low; word valid each cycle sampled 0
//  imData       in   16      pixel word, valid when imDmar==0
//  imRdAddr     in   ADDR_W  read address into the ready bank
//  omRdData     out  16      mem[read bank][imRdAddr], registered
//  omLineReady  out  1       read bank holds a complete line
//  omRdBank     out  1       index of bank currently presented for reading
//  imLineAck    in   1       release read bank; honoured only when omLineReady==1
//  omLineNum    out  ROW_W   number of the line in the read bank (0..ROW-1)
//  omFrameDone  out  1       1-cycle pulse when line ROW-1 completes capture
//  omLenErr     out  1       1-cycle pulse: line shorter or longer than COL
//  omOverrun    out  1       1-cycle pulse: line arrived with both banks full, dropped
// BEHAVIOUR
//  Reset: all outputs 0; both banks free; write bank=read bank=0; line count 0;
//   FSM=IDLE. Memory contents not reset. Reset mid-line discards the partial line.
//  FSM states IDLE, RECV, TAIL, DROP:
//   IDLE: imDmar==0 and write bank free -> write imData at addr 0, wcnt=1, RECV.
//         imDmar==0 and write bank full -> pulse omOverrun, DROP (word discarded).
//   RECV: imDmar==0 -> write at wcnt, wcnt+1. Write of addr COL-1 marks write bank
//         full, tags it with current line count, toggles write bank, -> TAIL.
//         imDmar==1 with wcnt<COL -> pulse omLenErr, bank stays free, line not
//         counted, -> IDLE.
//   TAIL: imDmar==1 -> IDLE. imDmar==0 -> extra words ignored; omLenErr pulses
//         once on first extra word.
//   DROP: words ignored; imDmar==1 -> IDLE. Dropped lines not counted.
//  Line count increments on each completed line; completing line ROW-1 pulses
//   omFrameDone in the cycle after the last write and wraps count to 0.
//  Read side: omLineReady = read bank full. omRdData valid 1 cycle after
//   imRdAddr (readable even when not ready; contents then undefined).
//   imLineAck with omLineReady=1 frees read bank; read bank toggles next cycle;
//   omLineReady then reflects the other bank. Ack when not ready: ignored.
//  Simultaneous line completion and ack in same cycle: both take effect; no loss.
//  Capture may begin in IDLE the cycle after TAIL/DROP exits (min 1 high cycle).
//  Addresses >= COL on imRdAddr: data undefined, no side effects.
// TESTING
//  COL=8,ROW=3: drive imDmar low 8 cycles with data 0..7 -> omLineReady=1,
//   omLineNum=0, reads addr 0..7 return 0..7 one cycle later.
//  Three lines without ack: lines 0,1 captured; third -> omOverrun pulse,
//   omLineReady stays 1, ack then shows line 0 then line 1.
//  imDmar low only 5 cycles -> omLenErr pulse, omLineReady stays 0, next full
//   line captured as line 0.
//  imDmar low 10 cycles -> line captured from first 8 words, one omLenErr pulse.
//  Three good lines with acks -> omFrameDone pulse after third; fourth line omLineNum=0.
//  Assert imRESET_N=0 at word 4 of a line -> all outputs 0 immediately, next line
//   captured cleanly as line 0 in bank 0.

Source files
------------

// File: rtl/line_receiver.sv
// Receive end of the line-transfer link: captures COL-word lines into a
// ping-pong buffer and presents completed lines through a registered read port.
module line_receiver #(
  parameter int COL    = 800,
  parameter int ROW    = 600,
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 10
) (
  input  logic              imCLOCK,
  input  logic              imRESET_N,
  input  logic              imDmar,
  input  logic [15:0]       imData,
  input  logic [ADDR_W-1:0] imRdAddr,
  output logic [15:0]       omRdData,
  output logic              omLineReady,
  output logic              omRdBank,
  input  logic              imLineAck,
  output logic [ROW_W-1:0]  omLineNum,
  output logic              omFrameDone,
  output logic              omLenErr,
  output logic              omOverrun
);

  typedef enum logic [1:0] {IDLE, RECV, TAIL, DROP} state_t;

  localparam logic [ADDR_W:0]  LAST_ADDR = (ADDR_W+1)'(COL - 1);
  localparam logic [ROW_W-1:0] LAST_LINE = ROW_W'(ROW - 1);

  state_t             stateReg, stateNext;
  logic [ADDR_W:0]    wcntReg;
  logic               wrBankReg, rdBankReg;
  logic [1:0]         bankFullReg;
  logic [ROW_W-1:0]   bankLineReg [2];
  logic [ROW_W-1:0]   lineCntReg;
  logic               tailErrReg;
  logic [15:0]        mem [2**(ADDR_W+1)];

  logic               wrEn;
  logic [ADDR_W-1:0]  wrAddr;
  logic               lineDone;
  logic               lenErrNext;
  logic               overrunNext;
  logic               frameNext;
  logic               ackTake;

  always_ff @(posedge imCLOCK or negedge imRESET_N) begin
    if (!imRESET_N) stateReg <= IDLE;
    else            stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (!imDmar) stateNext = bankFullReg[wrBankReg] ? DROP : RECV;
      RECV: begin
        if (imDmar)                      stateNext = IDLE;
        else if (wcntReg == LAST_ADDR)   stateNext = TAIL;
      end
      TAIL, DROP: if (imDmar) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    wrEn        = 1'b0;
    wrAddr      = '0;
    lineDone    = 1'b0;
    lenErrNext  = 1'b0;
    overrunNext = 1'b0;
    case (stateReg)
      IDLE: begin
        wrEn        = !imDmar && !bankFullReg[wrBankReg];
        overrunNext = !imDmar &&  bankFullReg[wrBankReg];
      end
      RECV: begin
        wrEn       = !imDmar;
        wrAddr     = wcntReg[ADDR_W-1:0];
        lineDone   = !imDmar && (wcntReg == LAST_ADDR);
        lenErrNext = imDmar;
      end
      TAIL: lenErrNext = !imDmar && !tailErrReg;
      default: ;
    endcase
  end

  assign frameNext = lineDone && (lineCntReg == LAST_LINE);
  // The write bank is never the full read bank, so completion and release
  // in the same cycle always touch different banks.
  assign ackTake   = imLineAck && bankFullReg[rdBankReg];

  always_ff @(posedge imCLOCK or negedge imRESET_N) begin
    if (!imRESET_N) begin
      wcntReg        <= '0;
      wrBankReg      <= 1'b0;
      rdBankReg      <= 1'b0;
      bankFullReg    <= '0;
      bankLineReg[0] <= '0;
      bankLineReg[1] <= '0;
      lineCntReg     <= '0;
      tailErrReg     <= 1'b0;
      omFrameDone    <= 1'b0;
      omLenErr       <= 1'b0;
      omOverrun      <= 1'b0;
    end else begin
      omFrameDone <= frameNext;
      omLenErr    <= lenErrNext;
      omOverrun   <= overrunNext;
      if (wrEn)
        wcntReg <= (stateReg == IDLE) ? (ADDR_W+1)'(1) : wcntReg + 1'b1;
      if (stateReg != TAIL)
        tailErrReg <= 1'b0;
      else if (lenErrNext)
        tailErrReg <= 1'b1;
      if (lineDone) begin
        bankFullReg[wrBankReg] <= 1'b1;
        bankLineReg[wrBankReg] <= lineCntReg;
        wrBankReg              <= ~wrBankReg;
        lineCntReg             <= frameNext ? '0 : lineCntReg + 1'b1;
      end
      if (ackTake) begin
        bankFullReg[rdBankReg] <= 1'b0;
        rdBankReg              <= ~rdBankReg;
      end
    end
  end

  always_ff @(posedge imCLOCK) begin
    if (wrEn) mem[{wrBankReg, wrAddr}] <= imData;
  end

  always_ff @(posedge imCLOCK or negedge imRESET_N) begin
    if (!imRESET_N) omRdData <= '0;
    else            omRdData <= mem[{rdBankReg, imRdAddr}];
  end

  assign omLineReady = bankFullReg[rdBankReg];
  assign omRdBank    = rdBankReg;
  assign omLineNum   = bankLineReg[rdBankReg];

endmodule

// File: tb/tb_line_receiver.sv
// Randomized scoreboard bench for line_receiver: the driver predicts captured
// lines and pulses at line level, independent monitors pop and compare them.
module tb_line_receiver;
  localparam int COL = 8, ROW = 3, ADDR_W = 4, ROW_W = 2;
  localparam int EV_LEN = 1, EV_OVR = 2, EV_FRAME = 3;

  logic              imCLOCK = 1'b0;
  logic              imRESET_N = 1'b0;
  logic              imDmar = 1'b1;
  logic [15:0]       imData = '0;
  logic [ADDR_W-1:0] imRdAddr = '0;
  logic              imLineAck = 1'b0;
  logic [15:0]       omRdData;
  logic              omLineReady, omRdBank, omFrameDone, omLenErr, omOverrun;
  logic [ROW_W-1:0]  omLineNum;

  line_receiver #(.COL(COL), .ROW(ROW), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .imCLOCK(imCLOCK), .imRESET_N(imRESET_N), .imDmar(imDmar), .imData(imData),
    .imRdAddr(imRdAddr), .omRdData(omRdData), .omLineReady(omLineReady),
    .omRdBank(omRdBank), .imLineAck(imLineAck), .omLineNum(omLineNum),
    .omFrameDone(omFrameDone), .omLenErr(omLenErr), .omOverrun(omOverrun)
  );

  always #5 imCLOCK = ~imCLOCK;

  int nChecks = 0, nFail = 0;

  // Reference model: lines held by the receiver, in delivery order.
  logic [COL*16-1:0] lineDataQ[$];
  int lineNumQ[$], lineBankQ[$], evQ[$];
  int occ = 0, modelLineCnt = 0, modelWrBank = 0;
  bit ackEnable = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  task automatic modelReset();
    occ = 0; modelLineCnt = 0; modelWrBank = 0;
    lineDataQ.delete(); lineNumQ.delete(); lineBankQ.delete(); evQ.delete();
  endtask

  task automatic doReset();
    @(negedge imCLOCK);
    imRESET_N = 1'b0; imDmar = 1'b1;
    #1;
    check("rst_lineReady", omLineReady, 0);
    check("rst_rdBank",    omRdBank,    0);
    check("rst_lineNum",   omLineNum,   0);
    check("rst_rdData",    omRdData,    0);
    check("rst_pulses",    {omFrameDone, omLenErr, omOverrun}, 0);
    modelReset();
    repeat (2) @(negedge imCLOCK);
    imRESET_N = 1'b1;
  endtask

  // Sends n words; the line-level outcome follows from whether both banks are held.
  task automatic sendLine(input int n, input bit seqData);
    bit drop;
    logic [COL*16-1:0] words;
    drop = 1'b0;
    words = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge imCLOCK);
      if (i == 0) begin
        drop = (occ == 2);
        if (drop) evQ.push_back(EV_OVR);
      end
      imDmar = 1'b0;
      imData = seqData ? 16'(i) : 16'($urandom);
      if (i < COL) words[i*16 +: 16] = imData;
      if (!drop && i == COL - 1) begin
        @(posedge imCLOCK); #1;
        lineDataQ.push_back(words);
        lineNumQ.push_back(modelLineCnt);
        lineBankQ.push_back(modelWrBank);
        occ++;
        if (modelLineCnt == ROW - 1) evQ.push_back(EV_FRAME);
        modelLineCnt = (modelLineCnt + 1) % ROW;
        modelWrBank ^= 1;
        if (n > COL) evQ.push_back(EV_LEN);
      end
    end
    if (!drop && n < COL) evQ.push_back(EV_LEN);
    @(negedge imCLOCK);
    imDmar = 1'b1; imData = '0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    ackEnable = 1'b1;
    while ((occ != 0 || lineNumQ.size() != 0 || evQ.size() != 0) && k < 3000) begin
      @(negedge imCLOCK); k++;
    end
    check("drain_pending", occ + lineNumQ.size() + evQ.size(), 0);
    repeat (4) @(negedge imCLOCK);
  endtask

  task automatic popEv(input int kind, input string name);
    if (evQ.size() == 0) check({name, "_unexpected"}, kind, 0);
    else                 check(name, kind, evQ.pop_front());
  endtask

  always @(negedge imCLOCK) begin
    if (imRESET_N) begin
      if (omFrameDone) popEv(EV_FRAME, "frameDone");
      if (omLenErr)    popEv(EV_LEN,   "lenErr");
      if (omOverrun)   popEv(EV_OVR,   "overrun");
    end
  end

  // Line consumer: reads every word of a ready line, then releases it.
  initial begin
    logic [COL*16-1:0] expWords;
    forever begin
      @(posedge imCLOCK); #2;
      if (imRESET_N && ackEnable && omLineReady) begin
        if (lineNumQ.size() == 0) begin
          check("lineReady_unexpected", omLineReady, 0);
          imLineAck = 1'b1;
          @(posedge imCLOCK); #1;
          imLineAck = 1'b0;
        end else begin
          expWords = lineDataQ.pop_front();
          check("lineNum", omLineNum, lineNumQ.pop_front());
          check("rdBank",  omRdBank,  lineBankQ.pop_front());
          for (int a = 0; a < COL; a++) begin
            imRdAddr = ADDR_W'(a);
            @(posedge imCLOCK); #2;
            check($sformatf("rdData[%0d]", a), omRdData, expWords[a*16 +: 16]);
          end
          imLineAck = 1'b1;
          @(posedge imCLOCK); #1;
          occ--;
          imLineAck = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    nFail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    doReset();

    // Single sequential line, consumed immediately.
    ackEnable = 1'b1;
    sendLine(COL, 1'b1);
    drain();

    // Three lines with no release: the third is dropped.
    doReset();
    ackEnable = 1'b0;
    for (int l = 0; l < 3; l++) begin
      sendLine(COL, 1'b0);
      @(negedge imCLOCK);
    end
    repeat (2) @(negedge imCLOCK);
    check("held_lineReady", omLineReady, 1);
    check("held_lineNum",   omLineNum,   0);
    drain();

    // Short line, then a full line taken as line 0.
    doReset();
    ackEnable = 1'b0;
    sendLine(5, 1'b0);
    repeat (2) @(negedge imCLOCK);
    check("short_lineReady", omLineReady, 0);
    sendLine(COL, 1'b0);
    drain();

    // Long line: first COL words kept, one length error.
    sendLine(COL + 2, 1'b0);
    drain();

    // Full frame plus wrap to line 0.
    doReset();
    for (int l = 0; l < ROW + 1; l++) begin
      sendLine(COL, 1'b0);
      drain();
    end

    // Reset in the middle of a line with a completed line already held.
    ackEnable = 1'b0;
    sendLine(COL, 1'b0);
    @(negedge imCLOCK);
    for (int i = 0; i < 4; i++) begin
      @(negedge imCLOCK);
      imDmar = 1'b0; imData = 16'($urandom);
    end
    doReset();
    sendLine(COL, 1'b1);
    drain();

    // Randomized mix of lengths, gaps and release behaviour.
    for (int l = 0; l < 60; l++) begin
      int r, n;
      ackEnable = ($urandom % 4) != 0;
      r = $urandom % 6;
      if (r == 3)      n = $urandom_range(1, COL - 1);
      else if (r == 4) n = $urandom_range(COL + 1, COL + 3);
      else             n = COL;
      sendLine(n, 1'b0);
      repeat ($urandom % 3) @(negedge imCLOCK);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
